// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift unit controller. Accepts one SLL/SRL/SRA request per
// valid/ready transaction and resolves the shift one shift-amount bit per
// clock (1, 2, 4, 8, 16 positions), replacing a single-cycle barrel shifter.
//
// Optional feature macro: SHIFT_SEQ_EARLY_EXIT_EN
//   When defined, the controller leaves SHIFT as soon as every remaining
//   shift-amount bit is zero (and skips SHIFT entirely for shamt==0).
//   Results are identical in both builds; only latency differs.
//
// Ports:
//   i_clk     in   1   clock, rising edge
//   i_rst_n   in   1   asynchronous active-low reset
//   i_valid   in   1   request valid
//   o_ready   out  1   request accepted when high (IDLE only)
//   i_data    in   32  operand
//   i_shamt   in   5   shift amount 0..31
//   i_op      in   2   00 SLL, 01 SRL, 11 SRA, 10 SRL
//   o_valid   out  1   result valid (DONE only)
//   i_ready   in   1   consumer accepts result
//   o_result  out  32  shifted result
//   o_busy    out  1   high whenever not IDLE
// -----------------------------------------------------------------------------
module shift_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  input  logic [1:0]  i_op,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_busy
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          k;
  logic [DATA_W-1:0]   work;
  logic [4:0]          shamt_q;
  logic [1:0]          op_q;
  logic                accept;
  logic                stage_en;
  logic [DATA_W-1:0]   work_stage;

  // One stage of the shifter: shift by 2^stage according to op.
  // op[0]==0 with op[1]==0 is SLL; op==2'b11 is SRA; 01 and 10 are SRL.
  function automatic logic [DATA_W-1:0] stage_shift(
    input logic [DATA_W-1:0] val,
    input logic [1:0]        op,
    input logic [2:0]        stage
  );
    logic signed [DATA_W-1:0] sval;
    logic [4:0]               amt;
    amt  = 5'd1 << stage;
    sval = $signed(val);
    case (op)
      2'b00:   stage_shift = val << amt;
      2'b11:   stage_shift = $unsigned(sval >>> amt);
      default: stage_shift = val >> amt;
    endcase
  endfunction

  assign accept     = (state == IDLE) && i_valid;
  assign stage_en   = |(shamt_q & (5'd1 << k));
  assign work_stage = stage_shift(work, op_q, k);

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  logic rem_zero;
  // Bits above the stage being processed are all zero: nothing left to do.
  assign rem_zero = ((shamt_q >> (k + 3'd1)) == 5'd0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
          state_nxt = (i_shamt == 5'd0) ? DONE : SHIFT;
`else
          state_nxt = SHIFT;
`endif
        end
      end
      SHIFT: begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        if (k == 3'd4 || rem_zero) state_nxt = DONE;
`else
        if (k == 3'd4) state_nxt = DONE;
`endif
      end
      DONE: begin
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      k       <= 3'd0;
      work    <= '0;
      shamt_q <= '0;
      op_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        work    <= i_data;
        shamt_q <= i_shamt;
        op_q    <= i_op;
        k       <= 3'd0;
      end else if (state == SHIFT) begin
        if (stage_en) work <= work_stage;
        // k stops at the last processed stage; it is cleared on next accept.
        if (state_nxt == SHIFT) k <= k + 3'd1;
      end
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_busy   = (state != IDLE);
  assign o_result = work;

endmodule
